// File: rtl/or_gate_pkg.sv
// Shared types and constants for the registered OR unit.
// Mode encoding is fixed; the stats counter width default lives here.
package or_gate_pkg;

    localparam int MODE_W         = 2;
    localparam int STAT_W_DEFAULT = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_OR     = 2'b00,
        MODE_REDUCE = 2'b01,
        MODE_ACCUM  = 2'b10,
        MODE_NOR    = 2'b11
    } mode_e;

    function automatic logic is_accum(input logic [MODE_W-1:0] mode);
        return mode_e'(mode) == MODE_ACCUM;
    endfunction

endpackage

// File: rtl/or_gate_core.sv
// Combinational datapath of the OR unit: selects OR / REDUCE / ACCUM / NOR.
// next_acc is always acc_base | a | b; the top decides whether to store it.
module or_gate_core
    import or_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  acc_base,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  next_acc
);

    logic [WIDTH-1:0] or_ab;

    always_comb begin
        or_ab    = a | b;
        next_acc = acc_base | or_ab;
        result   = '0;
        case (mode_e'(mode))
            MODE_OR:     result = or_ab;
            // Only bit 0 carries the reduction; upper bits stay zero.
            MODE_REDUCE: result[0] = |or_ab;
            MODE_ACCUM:  result = next_acc;
            MODE_NOR:    result = ~or_ab;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/or_gate.sv
// Registered OR unit: one-cycle latency result, sticky accumulator, optional
// nonzero-result counter enabled by the OR_GATE_STATS_EN macro.
module or_gate
    import or_gate_pkg::*;
#(
    parameter int WIDTH = 1
`ifdef OR_GATE_STATS_EN
    , parameter int STAT_W = STAT_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              acc_clr,
    output logic [WIDTH-1:0]  f,
    output logic              out_valid,
    output logic [WIDTH-1:0]  acc
`ifdef OR_GATE_STATS_EN
    , output logic [STAT_W-1:0] stat_count
`endif
);

    logic [WIDTH-1:0] f_q, f_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] next_acc;

    // A clear in the same cycle as an ACCUM makes the accumulation start from zero.
    assign acc_base = acc_clr ? '0 : acc_q;

    or_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (a),
        .b        (b),
        .mode     (mode),
        .acc_base (acc_base),
        .result   (result),
        .next_acc (next_acc)
    );

    always_comb begin
        f_d         = f_q;
        out_valid_d = in_valid;
        acc_d       = acc_base;
        if (in_valid) begin
            f_d = result;
            if (is_accum(mode)) begin
                acc_d = next_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q         <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
        end
    end

    assign f         = f_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;

`ifdef OR_GATE_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (in_valid && (|result) && (stat_q != '1)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: a WIDTH=1 and a WIDTH=8 instance share one
// clock; directed steps then random traffic, both checked against a
// transaction-level reference model.
module tb_or_gate;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // WIDTH=1 instance
    logic       rst1, iv1, clr1;
    logic [1:0] md1;
    logic [0:0] a1, b1;
    logic [0:0] f1, acc1;
    logic       ov1;
    // WIDTH=8 instance
    logic       rst8, iv8, clr8;
    logic [1:0] md8;
    logic [7:0] a8, b8;
    logic [7:0] f8, acc8;
    logic       ov8;
`ifdef OR_GATE_STATS_EN
    logic [15:0] st1;
    logic [1:0]  st8;
`endif

    or_gate #(
        .WIDTH (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .in_valid   (iv1),
        .mode       (md1),
        .a          (a1),
        .b          (b1),
        .acc_clr    (clr1),
        .f          (f1),
        .out_valid  (ov1),
        .acc        (acc1)
`ifdef OR_GATE_STATS_EN
        , .stat_count (st1)
`endif
    );

    or_gate #(
        .WIDTH (8)
`ifdef OR_GATE_STATS_EN
        , .STAT_W (2)
`endif
    ) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .in_valid   (iv8),
        .mode       (md8),
        .a          (a8),
        .b          (b8),
        .acc_clr    (clr8),
        .f          (f8),
        .out_valid  (ov8),
        .acc        (acc8)
`ifdef OR_GATE_STATS_EN
        , .stat_count (st8)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = WIDTH 1, index 1 = WIDTH 8
    logic [63:0] m_f   [2];
    logic        m_ov  [2];
    logic [63:0] m_acc [2];
    longint      m_st  [2];
    longint      st_max[2] = '{65535, 3};

    function automatic logic [63:0] width_mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_step(input int idx, input int w, input logic r,
                              input logic iv, input logic [1:0] md,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic clr);
        logic [63:0] base, res, msk;
        msk = width_mask(w);
        if (r) begin
            m_f[idx] = 0; m_ov[idx] = 0; m_acc[idx] = 0; m_st[idx] = 0;
            return;
        end
        base = clr ? 64'd0 : m_acc[idx];
        m_acc[idx] = base;
        m_ov[idx]  = iv;
        if (iv) begin
            case (md)
                2'd0: res = a | b;
                2'd1: res = ((a | b) != 0) ? 64'd1 : 64'd0;
                2'd2: begin res = base | a | b; m_acc[idx] = res; end
                default: res = ~(a | b) & msk;
            endcase
            m_f[idx] = res & msk;
            if (m_f[idx] != 0 && m_st[idx] < st_max[idx]) m_st[idx]++;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update models, compare every output against them.
    task automatic cycle();
        @(posedge clk);
        model_step(0, 1, rst1, iv1, md1, {63'd0, a1}, {63'd0, b1}, clr1);
        model_step(1, 8, rst8, iv8, md8, {56'd0, a8}, {56'd0, b8}, clr8);
        #1;
        check("w1_f",    {63'd0, f1},   m_f[0]);
        check("w1_ov",   {63'd0, ov1},  {63'd0, m_ov[0]});
        check("w1_acc",  {63'd0, acc1}, m_acc[0]);
        check("w8_f",    {56'd0, f8},   m_f[1]);
        check("w8_ov",   {63'd0, ov8},  {63'd0, m_ov[1]});
        check("w8_acc",  {56'd0, acc8}, m_acc[1]);
`ifdef OR_GATE_STATS_EN
        check("w1_stat", {48'd0, st1},  64'(m_st[0]));
        check("w8_stat", {62'd0, st8},  64'(m_st[1]));
`endif
    endtask

    task automatic drive1(input logic iv, input logic [1:0] md, input logic a, input logic b);
        iv1 = iv; md1 = md; a1 = a; b1 = b;
    endtask

    task automatic drive8(input logic iv, input logic [1:0] md, input logic [7:0] a,
                          input logic [7:0] b, input logic clr);
        iv8 = iv; md8 = md; a8 = a; b8 = b; clr8 = clr;
    endtask

    initial begin
        rst1 = 1; rst8 = 1; clr1 = 0;
        drive1(0, 2'd0, 0, 0);
        drive8(0, 2'd0, 8'h00, 8'h00, 0);
        cycle(); cycle();
        check("reset_f8",   {56'd0, f8},   64'h0);
        check("reset_acc8", {56'd0, acc8}, 64'h0);
        check("reset_ov8",  {63'd0, ov8},  64'h0);
        rst1 = 0; rst8 = 0;

        // WIDTH=1 OR truth table on consecutive cycles
        drive1(1, 2'd0, 0, 0); cycle(); check("w1_or_00", {63'd0, f1}, 64'd0);
        drive1(1, 2'd0, 0, 1); cycle(); check("w1_or_01", {63'd0, f1}, 64'd1);
        drive1(1, 2'd0, 1, 0); cycle(); check("w1_or_10", {63'd0, f1}, 64'd1);
        drive1(1, 2'd0, 1, 1); cycle(); check("w1_or_11", {63'd0, f1}, 64'd1);
        check("w1_or_ov", {63'd0, ov1}, 64'd1);
        drive1(1, 2'd1, 0, 1); cycle(); check("w1_reduce", {63'd0, f1}, 64'd1);
        drive1(0, 2'd0, 0, 0);

        // WIDTH=8 NOR and REDUCE
        drive8(1, 2'd3, 8'hF0, 8'h0C, 0); cycle(); check("w8_nor", {56'd0, f8}, 64'h03);
        drive8(1, 2'd1, 8'h00, 8'h40, 0); cycle(); check("w8_reduce", {56'd0, f8}, 64'h01);
        drive8(1, 2'd1, 8'h00, 8'h00, 0); cycle(); check("w8_reduce0", {56'd0, f8}, 64'h00);

        // Accumulate, idle hold, clear-with-accumulate
        drive8(1, 2'd2, 8'h01, 8'h00, 0); cycle(); check("w8_acc1", {56'd0, acc8}, 64'h01);
        drive8(1, 2'd2, 8'h10, 8'h02, 0); cycle(); check("w8_acc2", {56'd0, f8}, 64'h13);
        check("w8_acc2_reg", {56'd0, acc8}, 64'h13);
        drive8(0, 2'd0, 8'hFF, 8'hFF, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("w8_hold_f",  {56'd0, f8},  64'h13);
            check("w8_hold_ov", {63'd0, ov8}, 64'h0);
        end
        drive8(1, 2'd2, 8'h80, 8'h00, 1); cycle(); check("w8_clr_accum", {56'd0, acc8}, 64'h80);
        check("w8_clr_accum_f", {56'd0, f8}, 64'h80);
        drive8(1, 2'd0, 8'h05, 8'h00, 1); cycle(); check("w8_clr_only", {56'd0, acc8}, 64'h00);
        drive8(1, 2'd3, 8'h00, 8'h00, 0); cycle(); check("w8_nor_acc_kept", {56'd0, acc8}, 64'h00);

        // Reset while a valid input is present
        drive8(1, 2'd2, 8'h3C, 8'h01, 0); cycle();
        rst8 = 1; drive8(1, 2'd0, 8'hAA, 8'h55, 0); cycle();
        check("w8_rst_f", {56'd0, f8}, 64'h0);
        check("w8_rst_ov", {63'd0, ov8}, 64'h0);
        rst8 = 0;

`ifdef OR_GATE_STATS_EN
        drive8(1, 2'd0, 8'h01, 8'h00, 0); cycle();
        drive8(1, 2'd0, 8'h02, 8'h00, 0); cycle();
        drive8(1, 2'd0, 8'h00, 8'h00, 0); cycle();
        check("stat_zero_no_inc", {62'd0, st8}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            drive8(1, 2'd3, 8'h00, 8'h00, 0); cycle();
        end
        check("stat_saturate", {62'd0, st8}, 64'd3);
        rst8 = 1; drive8(0, 2'd0, 8'h00, 8'h00, 0); cycle();
        check("stat_rst", {62'd0, st8}, 64'd0);
        rst8 = 0;
`endif

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            rst1 = ($urandom_range(0, 39) == 0);
            rst8 = ($urandom_range(0, 39) == 0);
            clr1 = ($urandom_range(0, 7) == 0);
            drive1($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive8($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                   $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
